// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver with 16x oversampling, 3-sample majority vote and
// run-time baud select latched at the start of each frame.
module uart_byte_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] set_baud,
  input  logic       rx,
  output logic [7:0] data_byte,
  output logic       rx_done,
  output logic       frame_err,
  output logic       uart_state
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // Last tick-counter value (N-1) for 16 ticks per bit at 50 MHz.
  function automatic logic [8:0] baud_last(input logic [2:0] sel);
    case (sel)
      3'd1:    baud_last = 9'd162;
      3'd2:    baud_last = 9'd80;
      3'd3:    baud_last = 9'd53;
      3'd4:    baud_last = 9'd26;
      default: baud_last = 9'd325;
    endcase
  endfunction

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs_prev;
  logic [2:0]             baud_q;
  logic [8:0]             tick_cnt;
  logic [3:0]             sample_idx;
  logic [3:0]             bit_cnt;
  logic                   samp6;
  logic                   samp7;
  logic [7:0]             shreg;

  logic rxs;
  logic tick;
  logic bit_val;
  logic start_edge;

  assign rxs        = sync_q[SYNC_STAGES-1];
  assign tick       = (state != IDLE) && (tick_cnt == baud_last(baud_q));
  assign bit_val    = (samp6 & samp7) | (samp6 & rxs) | (samp7 & rxs);
  assign start_edge = rxs_prev & ~rxs;

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the synchronizer and edge history reset to the idle-line level,
      // so a line that is already low after reset is not taken as a start edge.
      sync_q     <= '1;
      rxs_prev   <= 1'b1;
      state      <= IDLE;
      baud_q     <= 3'd0;
      tick_cnt   <= 9'd0;
      sample_idx <= 4'd0;
      bit_cnt    <= 4'd0;
      samp6      <= 1'b1;
      samp7      <= 1'b1;
      shreg      <= 8'h00;
      data_byte  <= 8'h00;
      rx_done    <= 1'b0;
      frame_err  <= 1'b0;
      uart_state <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], rx};
      rxs_prev <= rxs;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;

      if (state == IDLE || tick) tick_cnt <= 9'd0;
      else                       tick_cnt <= tick_cnt + 9'd1;

      if (tick) begin
        sample_idx <= sample_idx + 4'd1;
        if (sample_idx == 4'd6) samp6 <= rxs;
        if (sample_idx == 4'd7) samp7 <= rxs;
      end

      case (state)
        IDLE: begin
          if (start_edge) begin
            state      <= START;
            baud_q     <= set_baud;
            sample_idx <= 4'd0;
            uart_state <= 1'b1;
          end
        end
        START: begin
          if (tick && sample_idx == 4'd8 && bit_val) begin
            state      <= IDLE;
            uart_state <= 1'b0;
          end else if (tick && sample_idx == 4'd15) begin
            state   <= DATA;
            bit_cnt <= 4'd0;
          end
        end
        DATA: begin
          if (tick && sample_idx == 4'd8) begin
            shreg   <= {bit_val, shreg[7:1]};
            bit_cnt <= bit_cnt + 4'd1;
          end else if (tick && sample_idx == 4'd15 && bit_cnt == 4'd8) begin
            state <= STOP;
          end
        end
        STOP: begin
          // Leave at mid-stop-bit so a back-to-back start edge is not missed.
          if (tick && sample_idx == 4'd8) begin
            if (bit_val) begin
              data_byte <= shreg;
              rx_done   <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state      <= IDLE;
            uart_state <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed + randomized bench for uart_byte_rx: frames are driven bit by bit
// and outcomes are predicted from frame timing and payload arithmetic.
module tb_uart_byte_rx;

  localparam int SYNC_STAGES = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] set_baud;
  logic       rx;
  logic [7:0] data_byte;
  logic       rx_done;
  logic       frame_err;
  logic       uart_state;

  uart_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .set_baud  (set_baud),
    .rx        (rx),
    .data_byte (data_byte),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .uart_state(uart_state)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed pulse history, sampled on the falling edge.
  int         done_cnt = 0;
  int         ferr_cnt = 0;
  int         both_cnt = 0;
  int         last_pulse_cyc = 0;
  logic [7:0] got_q[$];

  always @(negedge clk) begin
    if (rx_done) begin
      done_cnt++;
      got_q.push_back(data_byte);
      last_pulse_cyc = cyc;
    end
    if (frame_err) begin
      ferr_cnt++;
      last_pulse_cyc = cyc;
    end
    if (rx_done && frame_err) both_cnt++;
  end

  int checks = 0;
  int errors = 0;

  // Reference model state: expected pulse counts and held byte.
  int         exp_done = 0;
  int         exp_ferr = 0;
  logic [7:0] exp_data = 8'h00;
  int         frame_start_cyc = 0;

  function automatic int clks_per_tick(input int sel);
    case (sel)
      1:       return 163;
      2:       return 81;
      3:       return 54;
      4:       return 27;
      default: return 326;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_win(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic check_byte(input string tag, input logic [7:0] exp);
    logic [31:0] obs;
    obs = (got_q.size() > 0) ? {24'h0, got_q.pop_front()} : 32'hFFFF_FFFF;
    check(tag, obs, {24'h0, exp});
  endtask

  // Stop-bit mid-point pulse: 9 full bits plus 9 ticks, plus input pipeline.
  task automatic check_pulse_time(input string tag, input int sel);
    int n;
    n = clks_per_tick(sel);
    check_win(tag, last_pulse_cyc - frame_start_cyc, 153 * n, 153 * n + SYNC_STAGES + 3);
  endtask

  task automatic send_frame(input logic [7:0] b, input int sel, input logic stop_bit,
                            input int stop_clks, input int chg_bit, input logic [2:0] chg_sel);
    int bit_clks;
    bit_clks = 16 * clks_per_tick(sel);
    frame_start_cyc = cyc;
    rx = 1'b0;
    repeat (bit_clks) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      if (i == chg_bit) set_baud = chg_sel;
      rx = b[i];
      repeat (bit_clks) @(negedge clk);
    end
    rx = stop_bit;
    repeat (stop_clks) @(negedge clk);
  endtask

  initial begin
    logic [7:0] rnd_byte;
    int         t0;
    int         k;

    rst = 1'b1;
    rx = 1'b1;
    set_baud = 3'd0;
    repeat (5) @(negedge clk);
    check("reset_data_byte", {24'h0, data_byte}, 32'h00);
    check("reset_rx_done", {31'h0, rx_done}, 32'h0);
    check("reset_frame_err", {31'h0, frame_err}, 32'h0);
    check("reset_uart_state", {31'h0, uart_state}, 32'h0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Basic byte at 57600.
    set_baud = 3'd3;
    send_frame(8'h55, 3, 1'b1, 9 * 54 + 40, -1, 3'd0);
    exp_done++;
    exp_data = 8'h55;
    check("basic_done_cnt", done_cnt, exp_done);
    check("basic_ferr_cnt", ferr_cnt, exp_ferr);
    check("basic_data_byte", {24'h0, data_byte}, {24'h0, exp_data});
    check_byte("basic_rx_byte", 8'h55);
    check_pulse_time("basic_done_time", 3);
    check("basic_uart_state", {31'h0, uart_state}, 32'h0);

    // Back-to-back frames at 115200, no idle gap.
    set_baud = 3'd4;
    send_frame(8'hA5, 4, 1'b1, 16 * 27, -1, 3'd0);
    check_pulse_time("b2b_first_time", 4);
    send_frame(8'h3C, 4, 1'b1, 9 * 27 + 40, -1, 3'd0);
    exp_done += 2;
    exp_data = 8'h3C;
    check("b2b_done_cnt", done_cnt, exp_done);
    check_byte("b2b_byte0", 8'hA5);
    check_byte("b2b_byte1", 8'h3C);
    check("b2b_data_byte", {24'h0, data_byte}, {24'h0, exp_data});
    check_pulse_time("b2b_second_time", 4);

    // Glitch: 1000-clock low pulse at 9600 is a false start resolved at index 8.
    set_baud = 3'd0;
    t0 = cyc;
    rx = 1'b0;
    repeat (500) @(negedge clk);
    check("glitch_busy", {31'h0, uart_state}, 32'h1);
    repeat (500) @(negedge clk);
    rx = 1'b1;
    repeat (t0 + 2900 - cyc) @(negedge clk);
    check("glitch_busy_before_idx8", {31'h0, uart_state}, 32'h1);
    repeat (50) @(negedge clk);
    check("glitch_idle_after_idx8", {31'h0, uart_state}, 32'h0);
    check("glitch_no_done", done_cnt, exp_done);
    check("glitch_no_ferr", ferr_cnt, exp_ferr);

    // Framing error at 38400; line stays low (break) past the stop bit.
    set_baud = 3'd2;
    send_frame(8'hF0, 2, 1'b0, 900, -1, 3'd0);
    exp_ferr++;
    check("ferr_cnt", ferr_cnt, exp_ferr);
    check("ferr_no_done", done_cnt, exp_done);
    check("ferr_data_kept", {24'h0, data_byte}, {24'h0, exp_data});
    check_pulse_time("ferr_time", 2);
    check("break_no_restart", {31'h0, uart_state}, 32'h0);
    rx = 1'b1;
    repeat (100) @(negedge clk);
    set_baud = 3'd4;
    rnd_byte = 8'($urandom);
    send_frame(rnd_byte, 4, 1'b1, 9 * 27 + 40, -1, 3'd0);
    exp_done++;
    exp_data = rnd_byte;
    check("post_break_done_cnt", done_cnt, exp_done);
    check_byte("post_break_byte", rnd_byte);
    check("post_break_data_byte", {24'h0, data_byte}, {24'h0, exp_data});

    // Reset in the middle of data bit 3 of 0xF9 (bits 3..7 and stop are high).
    set_baud = 3'd4;
    rx = 1'b0;
    repeat (432) @(negedge clk);
    rx = 1'b1;
    repeat (432) @(negedge clk);
    rx = 1'b0;
    repeat (864) @(negedge clk);
    rx = 1'b1;
    k = $urandom_range(400, 20);
    repeat (k) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    exp_data = 8'h00;
    check("midrst_data_byte", {24'h0, data_byte}, {24'h0, exp_data});
    check("midrst_rx_done", {31'h0, rx_done}, 32'h0);
    check("midrst_frame_err", {31'h0, frame_err}, 32'h0);
    check("midrst_uart_state", {31'h0, uart_state}, 32'h0);
    rst = 1'b0;
    repeat (3 * 432) @(negedge clk);
    check("midrst_no_done", done_cnt, exp_done);
    check("midrst_no_ferr", ferr_cnt, exp_ferr);
    repeat (50) @(negedge clk);
    send_frame(8'h81, 4, 1'b1, 9 * 27 + 40, -1, 3'd0);
    exp_done++;
    exp_data = 8'h81;
    check_byte("midrst_next_byte", 8'h81);
    check("midrst_next_data_byte", {24'h0, data_byte}, {24'h0, exp_data});

    // Out-of-range select defaults to 9600; select changed mid-frame is ignored.
    set_baud = 3'd7;
    send_frame(8'h0F, 0, 1'b1, 9 * 326 + 40, 3, 3'($urandom_range(4, 1)));
    exp_done++;
    exp_data = 8'h0F;
    check("latch_done_cnt", done_cnt, exp_done);
    check_byte("latch_byte", 8'h0F);
    check("latch_data_byte", {24'h0, data_byte}, {24'h0, exp_data});
    check_pulse_time("latch_done_time", 0);

    check("never_both_pulses", both_cnt, 0);
    check("no_extra_bytes", got_q.size(), 0);
    check("total_ferr", ferr_cnt, exp_ferr);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_byte_rx.md
UART_BYTE_RX -- requirements
Module: uart_byte_rx

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; it SHALL have no other clock or reset.
REQ-002 Parameter: SYNC_STAGES, default 2, number of flip-flops in the rx input synchronizer (legal values >= 2).
REQ-003 Port: clk  input  1  system clock, 50 MHz nominal; all logic on its rising edge.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: set_baud  input  3  baud select: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200, 5-7=9600.
REQ-006 Port: rx  input  1  asynchronous serial line; idle high.
REQ-007 Port: data_byte  output  8  last correctly framed received byte.
REQ-008 Port: rx_done  output  1  one-cycle pulse; data_byte was updated this cycle.
REQ-009 Port: frame_err  output  1  one-cycle pulse; stop bit was sampled low.
REQ-010 Port: uart_state  output  1  1 while a frame is being received (state != IDLE).

Function
REQ-011 rx SHALL pass through SYNC_STAGES flip-flops, with all stages reset to 1; "rxs" below means the synchronizer output.
REQ-012 A sample tick SHALL occur once every N clocks, where N = 326, 163, 81, 54, 27 for set_baud 0-4 (5-7 use 326); this gives 16 ticks per bit.
REQ-013 The tick counter SHALL count 0..N-1 and wrap, and SHALL be held at 0 while in IDLE.
REQ-014 set_baud SHALL be latched on start detection; changes to set_baud during a frame SHALL have no effect until the next frame.
REQ-015 A 4-bit sample index 0..15 SHALL advance on each tick, wrap 15->0, and be cleared to 0 on start detection.
REQ-016 On the tick with sample index 6, 7 and 8, rxs SHALL be recorded; on the tick at index 8 the bit value SHALL be the majority of those 3 samples.
REQ-017 The state machine SHALL have four states: IDLE, START, DATA, STOP.
REQ-018 IDLE->START SHALL occur on a falling edge of rxs (previous rxs 1, current rxs 0).
REQ-019 START: if the bit value at index 8 is 1, the block SHALL return to IDLE (false start) with no output pulse; otherwise, at the index-15 tick it SHALL go to DATA with bit count 0.
REQ-020 DATA: at index 8 the bit value SHALL be shifted in LSB-first; after the 8th bit, at the index-15 tick, the block SHALL go to STOP.
REQ-021 STOP, bit value 1: data_byte SHALL be loaded, rx_done SHALL be 1 for exactly one cycle, and the block SHALL go to IDLE.
REQ-022 STOP, bit value 0: frame_err SHALL be 1 for one cycle, data_byte SHALL be unchanged, rx_done SHALL stay 0, and the block SHALL go to IDLE.
REQ-023 Both the rx_done and frame_err pulses SHALL occur in the clock cycle after the stop-bit index-8 tick.
REQ-024 Because STOP exits at mid-stop-bit, a start edge occurring half a bit later SHALL be detected (back-to-back frames).
REQ-025 After a low stop bit (break condition), the block SHALL not start a new frame until rxs has returned high and then fallen.
REQ-026 rx_done and frame_err SHALL never be asserted in the same cycle.
REQ-027 uart_state SHALL be 1 from the cycle after start detection until the cycle the block returns to IDLE.

Reset
REQ-028 On rst=1 at a clock edge, the following SHALL be cleared regardless of state (including mid-frame):
- state -> IDLE
- counters -> 0
- shift register -> 0
- data_byte = 0x00
- rx_done = 0
- frame_err = 0
- uart_state = 0
- synchronizer stages and previous rxs -> 1
REQ-029 After reset is released, a partially received frame SHALL be ignored: no pulse is produced until the next falling edge.

Verification
REQ-030 Basic byte: set_baud=3 (864 clk/bit); drive 0x55 with 1 stop bit -> one rx_done pulse, data_byte=0x55, frame_err=0, uart_state returns 0.
REQ-031 Back-to-back: set_baud=4; drive 0xA5 then 0x3C with no idle gap -> two rx_done pulses, data_byte=0xA5 then 0x3C.
REQ-032 Glitch: set_baud=0; drive rx low for 1000 clk, then high -> no rx_done and no frame_err; uart_state returns 0 after the index-8 tick of START.
REQ-033 Framing error: set_baud=2; drive 0xF0 with a low stop bit -> frame_err pulse, data_byte keeps its prior value, no new frame starts until rx has risen and fallen again.
REQ-034 Reset mid-frame: assert rst for 1 cycle during DATA bit 3 -> all outputs 0 next cycle; remaining bits produce no rx_done; the following frame 0x81 is received correctly.
REQ-035 Baud default and latch: set_baud=7, drive 0x0F at 9600 -> data_byte=0x0F; changing set_baud mid-frame does not corrupt the byte.
